asip_decode_stage: RTL

Registered, parametrised instruction-decode pipeline stage for the stepper-motor ASIP, sitting between instruction fetch and the execute/motor-control datapath. Decodes the 6-bit major opcode into a one-hot operation vector, extracts a width-generalised immediate and flags illegal encodings. Transfers use valid/ready on both sides. A PAUSED state stalls fetch after a `pause` instruction until resumed, and a flush input kills in-flight decode on taken branches.

---
 rtl/asip_pkg.sv | 36 +++
 rtl/asip_decode_stage_if.sv | 31 +++
 rtl/asip_opcode_decode.sv | 27 ++
 rtl/asip_decode_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/asip_pkg.sv
// Shared definitions for the stepper-motor ASIP decode path: op indices,
// opcode patterns and the decode-stage state enum.
package asip_pkg;

  localparam int unsigned NUM_OPS = 12;

  localparam int unsigned BR     = 0;
  localparam int unsigned BRZ    = 1;
  localparam int unsigned ADDI   = 2;
  localparam int unsigned SUBI   = 3;
  localparam int unsigned SR0    = 4;
  localparam int unsigned SRH0   = 5;
  localparam int unsigned CLR    = 6;
  localparam int unsigned MOV    = 7;
  localparam int unsigned MOVA   = 8;
  localparam int unsigned MOVR   = 9;
  localparam int unsigned MOVRHS = 10;
  localparam int unsigned PAUSE  = 11;

  // Prefix patterns: 3-bit groups match o[5:3], 4-bit groups match o[5:2]
  localparam logic [2:0] OPC_BR     = 3'b100;
  localparam logic [2:0] OPC_BRZ    = 3'b101;
  localparam logic [2:0] OPC_ADDI   = 3'b000;
  localparam logic [2:0] OPC_SUBI   = 3'b001;
  localparam logic [3:0] OPC_SR0    = 4'b0100;
  localparam logic [3:0] OPC_SRH0   = 4'b0101;
  localparam logic [3:0] OPC_MOV    = 4'b0111;
  localparam logic [5:0] OPC_CLR    = 6'b011000;
  localparam logic [5:0] OPC_MOVA   = 6'b110000;
  localparam logic [5:0] OPC_MOVR   = 6'b110001;
  localparam logic [5:0] OPC_MOVRHS = 6'b110010;
  localparam logic [5:0] OPC_PAUSE  = 6'b111111;

  typedef enum logic [0:0] {RUN, PAUSED} state_e;

endpackage

// File: rtl/asip_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface asip_decode_stage_if #(
  parameter int unsigned IW    = 6,
  parameter int unsigned CNT_W = 8
);
  import asip_pkg::*;

  logic                 in_valid;
  logic [IW-1:0]        in_instr;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_OPS-1:0]   out_op;
  logic [IW-4:0]        out_imm;
  logic                 out_illegal;
  logic                 flush;
  logic                 resume;
  logic                 paused;
  logic [CNT_W-1:0]     illegal_cnt;

  modport slave (
    input  in_valid, in_instr, out_ready, flush, resume,
    output in_ready, out_valid, out_op, out_imm, out_illegal, paused, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, out_ready, flush, resume,
    input  in_ready, out_valid, out_op, out_imm, out_illegal, paused, illegal_cnt
  );

endinterface

// File: rtl/asip_opcode_decode.sv
// Combinational 6-bit major-opcode decoder: one-hot operation plus illegal flag.
module asip_opcode_decode
  import asip_pkg::*;
(
  input  logic [5:0]         opcode,
  output logic [NUM_OPS-1:0] op,
  output logic               illegal
);

  always_comb begin
    op = '0;
    if      (opcode[5:3] == OPC_BR)     op[BR]     = 1'b1;
    else if (opcode[5:3] == OPC_BRZ)    op[BRZ]    = 1'b1;
    else if (opcode[5:3] == OPC_ADDI)   op[ADDI]   = 1'b1;
    else if (opcode[5:3] == OPC_SUBI)   op[SUBI]   = 1'b1;
    else if (opcode[5:2] == OPC_SR0)    op[SR0]    = 1'b1;
    else if (opcode[5:2] == OPC_SRH0)   op[SRH0]   = 1'b1;
    else if (opcode[5:2] == OPC_MOV)    op[MOV]    = 1'b1;
    else if (opcode      == OPC_CLR)    op[CLR]    = 1'b1;
    else if (opcode      == OPC_MOVA)   op[MOVA]   = 1'b1;
    else if (opcode      == OPC_MOVR)   op[MOVR]   = 1'b1;
    else if (opcode      == OPC_MOVRHS) op[MOVRHS] = 1'b1;
    else if (opcode      == OPC_PAUSE)  op[PAUSE]  = 1'b1;
    illegal = ~|op;
  end

endmodule

// File: rtl/asip_decode_stage.sv
// Registered decode stage: valid/ready on both sides, pause/resume stall of
// fetch, synchronous flush and a saturating illegal-instruction counter.
module asip_decode_stage
  import asip_pkg::*;
#(
  parameter int unsigned IW    = 6,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                rst_n,
  asip_decode_stage_if.slave bus
);

  state_e               state_q, state_d;
  logic                 out_valid_q;
  logic [NUM_OPS-1:0]   out_op_q;
  logic [IW-4:0]        out_imm_q;
  logic                 out_illegal_q;
  logic [CNT_W-1:0]     illegal_cnt_q;

  logic [NUM_OPS-1:0]   op_dec;
  logic                 illegal_dec;
  logic [IW-4:0]        imm_d;
  logic                 in_ready;
  logic                 accept;

  asip_opcode_decode u_opcode_decode (
    .opcode  (bus.in_instr[IW-1 -: 6]),
    .op      (op_dec),
    .illegal (illegal_dec)
  );

  // Branch/arith carry the full field below the 3-bit group; shifts/mov one bit less
  always_comb begin
    imm_d = '0;
    if (op_dec[BR] || op_dec[BRZ] || op_dec[ADDI] || op_dec[SUBI]) begin
      imm_d = bus.in_instr[IW-4:0];
    end else if (op_dec[SR0] || op_dec[SRH0] || op_dec[MOV]) begin
      imm_d = {1'b0, bus.in_instr[IW-5:0]};
    end
  end

  assign in_ready = (state_q == RUN) && !bus.flush && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = RUN;
    end else if (accept && op_dec[PAUSE]) begin
      state_d = PAUSED;
    end else if (state_q == PAUSED && bus.resume) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      out_valid_q   <= 1'b0;
      out_op_q      <= '0;
      out_imm_q     <= '0;
      out_illegal_q <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q   <= 1'b1;
        out_op_q      <= op_dec;
        out_imm_q     <= imm_d;
        out_illegal_q <= illegal_dec;
        if (illegal_dec && illegal_cnt_q != '1) begin
          illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op      = out_op_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.paused      = (state_q == PAUSED);
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule
